// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory fetch bus: request/grant plus read-data/valid return.
// One outstanding request at a time; the fetch unit is the master.
//
// Signals:
//   imem_req     master -> slave  fetch request valid
//   imem_addr    master -> slave  word-aligned fetch address
//   imem_gnt     slave  -> master request accepted this cycle
//   imem_rvalid  slave  -> master read data valid
//   imem_rdata   slave  -> master fetched instruction word
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int WORD_LEN = 32
) ();

  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [WORD_LEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage, producer end of the IF/ID interface. Issues word
// fetches over a req/gnt/rvalid bus (one outstanding request), buffers the
// returned words in a small prefetch FIFO and drives the registered IF/ID
// outputs, honouring decode stalls and taken-branch redirects.
//
// Parameters:
//   WORD_LEN    instruction/address width
//   FIFO_DEPTH  prefetch FIFO entries (power of two, >= 2)
//   RESET_PC    first fetch address after reset
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   hazard_detected_in   decode stall: hold IF/ID outputs, no FIFO pop
//   br_taken_in          taken branch resolved in decode this cycle
//   br_target_in         redirect address (low two bits ignored)
//   imem                 fetch bus, master side (see if_fetch_unit_if)
//   instruction_out      IF/ID instruction (0 = bubble)
//   pc_plus4_out         address of instruction_out + 4
//   valid_out            instruction_out is a real fetched instruction
//
// Optional feature (define IF_PERF_CNT_EN):
//   stall_cnt_out        saturating count of stall cycles (hazard, no branch)
//   flush_cnt_out        saturating count of branch-redirect cycles
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int                  WORD_LEN   = 32,
  parameter int                  FIFO_DEPTH = 2,
  parameter logic [WORD_LEN-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected_in,
  input  logic                br_taken_in,
  input  logic [WORD_LEN-1:0] br_target_in,
  if_fetch_unit_if.master     imem,
  output logic [WORD_LEN-1:0] instruction_out,
  output logic [WORD_LEN-1:0] pc_plus4_out,
  output logic                valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt_out,
  output logic [31:0]         flush_cnt_out
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WORD_LEN-1:0] ALIGN_MASK = {{(WORD_LEN-2){1'b1}}, 2'b00};
  localparam logic [WORD_LEN-1:0] PC_STEP    = WORD_LEN'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_LEN-1:0] req_addr_q, req_addr_d;

  logic [WORD_LEN-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [WORD_LEN-1:0] fifo_instr_d [FIFO_DEPTH];
  logic [WORD_LEN-1:0] fifo_pc4_q   [FIFO_DEPTH];
  logic [WORD_LEN-1:0] fifo_pc4_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic [WORD_LEN-1:0] pc4_q, pc4_d;
  logic                valid_q, valid_d;

  logic pending;
  logic req;
  logic fire;
  logic push;
  logic pop;

  // Only request when the word is guaranteed a FIFO slot (buffered plus
  // in-flight below capacity), so the FIFO can never overflow. A redirect
  // this cycle suppresses the request since its address is already stale.
  // Request is forced low while reset is held.
  assign pending = (state_q == S_WAIT);
  assign req     = !rst && (state_q == S_IDLE) && !br_taken_in &&
                   ((count_q + CNT_W'(pending)) < CNT_W'(FIFO_DEPTH));
  assign fire    = req && imem.imem_gnt;
  assign push    = (state_q == S_WAIT) && imem.imem_rvalid && !br_taken_in;
  assign pop     = !br_taken_in && !hazard_detected_in && (count_q != '0);

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_q & ALIGN_MASK;

  assign instruction_out = instr_q;
  assign pc_plus4_out    = pc4_q;
  assign valid_out       = valid_q;

  // Fetch FSM and fetch address. A redirect always reloads fetch_pc; a
  // response still in flight at that point is routed to DISCARD so it is
  // swallowed instead of entering the FIFO.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (br_taken_in) begin
          if (imem.imem_gnt) begin
            state_d = S_DISCARD;
          end
        end else if (fire) begin
          state_d    = S_WAIT;
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = S_IDLE;
        end else if (br_taken_in) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem.imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (br_taken_in) begin
      fetch_pc_d = br_target_in & ALIGN_MASK;
    end
  end

  // Prefetch FIFO and IF/ID register. Pop reads the pre-edge head, so a word
  // pushed this cycle reaches the outputs one cycle later at the earliest.
  // Stalls freeze the outputs but still let returning data be buffered.
  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc4_d   = fifo_pc4_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    if (br_taken_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      instr_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem.imem_rdata;
        fifo_pc4_d[wr_ptr_q]   = req_addr_q + PC_STEP;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (!hazard_detected_in) begin
        if (pop) begin
          instr_d  = fifo_instr_q[rd_ptr_q];
          pc4_d    = fifo_pc4_q[rd_ptr_q];
          valid_d  = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc4_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc4_q   <= fifo_pc4_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a branch cycle counts as a flush, never a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_detected_in && !br_taken_in && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (br_taken_in && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. The bench plays the instruction
// memory (random grant and latency, one outstanding request) and keeps a
// transaction-level model: a queue of words owed to decode, the expected
// fetch address and the expected IF/ID register contents.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int          WORD_LEN   = 32;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz;
  logic        br;
  logic [31:0] target;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_out;
  logic [31:0] flush_cnt_out;
`endif

  if_fetch_unit_if #(.WORD_LEN(WORD_LEN)) imem_bus ();

  if_fetch_unit #(
    .WORD_LEN  (WORD_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hazard_detected_in(hz),
    .br_taken_in       (br),
    .br_target_in      (target),
    .imem              (imem_bus),
    .instruction_out   (instruction_out),
    .pc_plus4_out      (pc_plus4_out),
    .valid_out         (valid_out)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt_out     (stall_cnt_out),
    .flush_cnt_out     (flush_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] q_instr [$];
  logic [31:0] q_pc4   [$];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] fa;
  logic [31:0] stall_m, flush_m;

  // Memory responder state
  bit          mem_busy, mem_wanted, mem_stale;
  logic [31:0] mem_addr;
  int          mem_lat_left;
  int          fixed_lat;
  int          max_lat;

  // Observations from the last applied cycle
  logic        last_req;
  logic [31:0] last_addr;
  bit          last_grant;
  logic [31:0] last_grant_addr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h8C22_0000;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    q_instr.delete();
    q_pc4.delete();
    m_instr    = '0;
    m_pc4      = '0;
    m_valid    = 1'b0;
    fa         = RESET_PC;
    stall_m    = '0;
    flush_m    = '0;
    mem_stale  = mem_busy;
    mem_wanted = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    hz = 1'b0;
    br = 1'b0;
    target = '0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    #1;
    checkOutput("rst_instr", instruction_out, 32'h0);
    checkOutput("rst_pc4", pc_plus4_out, 32'h0);
    checkOutput("rst_valid", valid_out, 32'h0);
    checkOutput("rst_req", imem_bus.imem_req, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_valid", valid_out, 32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt_out, 32'h0);
    checkOutput("rst_flush_cnt", flush_cnt_out, 32'h0);
`endif
    rst = 1'b0;
    modelReset();
  endtask

  // One clock cycle: drive inputs and the memory response, check the request
  // side, clock, then advance the model and check the IF/ID outputs.
  task automatic applyStimulus(input bit h, input bit b, input logic [31:0] t,
                               input bit g_ok);
    bit          rv;
    bit          fire;
    bit          wanted_now;
    bit          exp_req;
    logic [31:0] rd;
    int          lat;

    hz = h;
    br = b;
    target = t;
    rv = mem_busy && (mem_lat_left == 0);
    rd = rv ? memWord(mem_addr) : 32'hDEAD_BEEF;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    imem_bus.imem_gnt    = 1'b0;
    #1;

    if (!mem_busy || mem_stale) begin
      exp_req = (q_instr.size() < FIFO_DEPTH) && !b;
      checkOutput("imem_req", imem_bus.imem_req, exp_req);
    end else begin
      checkOutput("imem_req_busy", imem_bus.imem_req, 32'h0);
    end
    if (imem_bus.imem_req === 1'b1) begin
      checkOutput("imem_addr", imem_bus.imem_addr, fa);
    end
    last_req  = imem_bus.imem_req;
    last_addr = imem_bus.imem_addr;
    fire = (imem_bus.imem_req === 1'b1) && !mem_busy && g_ok;
    imem_bus.imem_gnt = fire;

    @(posedge clk);
    #1;

    wanted_now = mem_wanted;
    if (rv) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy) begin
      mem_lat_left--;
    end
    if (fire) begin
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, max_lat));
      mem_busy        = 1'b1;
      mem_wanted      = 1'b1;
      mem_addr        = last_addr;
      mem_lat_left    = lat - 1;
      fa              = fa + 32'd4;
      last_grant      = 1'b1;
      last_grant_addr = last_addr;
    end

    if (b) begin
      fa = t & 32'hFFFF_FFFC;
      q_instr.delete();
      q_pc4.delete();
      mem_wanted = 1'b0;
      m_instr = '0;
      m_valid = 1'b0;
      flush_m = flush_m + 32'd1;
    end else begin
      if (h) begin
        stall_m = stall_m + 32'd1;
      end else if (q_instr.size() > 0) begin
        m_instr = q_instr.pop_front();
        m_pc4   = q_pc4.pop_front();
        m_valid = 1'b1;
      end else begin
        m_instr = '0;
        m_valid = 1'b0;
      end
      if (rv && wanted_now) begin
        q_instr.push_back(rd);
        q_pc4.push_back(mem_addr + 32'd4);
      end
    end

    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("instruction_out", instruction_out, m_instr);
    checkOutput("pc_plus4_out", pc_plus4_out, m_pc4);
`ifdef IF_PERF_CNT_EN
    checkOutput("stall_cnt", stall_cnt_out, stall_m);
    checkOutput("flush_cnt", flush_cnt_out, flush_m);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          found;
    logic [31:0] saved;
    logic [31:0] t;
    bit          h, b, g;
    int          dut_delivered;

    rst = 1'b0;
    hz = 1'b0;
    br = 1'b0;
    target = '0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    mem_busy = 1'b0;
    mem_wanted = 1'b0;
    mem_stale = 1'b0;
    mem_addr = '0;
    mem_lat_left = 0;
    fixed_lat = 1;
    max_lat = 4;
    last_grant = 1'b0;
    last_grant_addr = '0;
    #2;
    doReset();

    $display("[TB] sequential fetch, gnt same cycle, rvalid one cycle later");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = (valid_out === 1'b1);
    end
    checkOutput("first_valid_seen", found, 32'h1);
    checkOutput("first_instr", instruction_out, 32'h2001_0005);
    checkOutput("first_pc4", pc_plus4_out, 32'h4);

    $display("[TB] decode stall for three cycles");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = (pc_plus4_out === 32'h8);
    end
    checkOutput("second_seen", found, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_hold_instr", instruction_out, 32'h8C22_0000);
      checkOutput("stall_hold_pc4", pc_plus4_out, 32'h8);
    end
    checkOutput("stall_req_dropped", last_req, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("release_req_still_low", last_req, 32'h0);
    checkOutput("resume_pc4", pc_plus4_out, 32'hC);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] branch to 0x40 while a fetch is outstanding");
    fixed_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = mem_busy && mem_wanted && (mem_lat_left == 1);
    end
    checkOutput("wait_state_reached", found, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    checkOutput("branch_bubble_valid", valid_out, 32'h0);
    checkOutput("branch_bubble_instr", instruction_out, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = (valid_out === 1'b1);
    end
    checkOutput("branch_target_seen", found, 32'h1);
    checkOutput("branch_target_pc4", pc_plus4_out, 32'h44);
    checkOutput("branch_target_instr", instruction_out, memWord(32'h40));

    $display("[TB] branch and stall together, unaligned target");
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1);
    checkOutput("br_hz_bubble", valid_out, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = (last_req === 1'b1);
    end
    checkOutput("br_hz_req_seen", found, 32'h1);
    checkOutput("br_hz_fetch_addr", last_addr, 32'h100);

    $display("[TB] grant withheld for five cycles");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    saved = fa;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("no_gnt_req_held", last_req, 32'h1);
      checkOutput("no_gnt_addr_held", last_addr, saved);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] reset during an outstanding fetch");
    fixed_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      found = mem_busy && mem_wanted && (mem_lat_left == 2);
    end
    checkOutput("grant_before_reset", found, 32'h1);
    doReset();
    last_grant = 1'b0;
    for (int i = 0; i < 20 && !last_grant; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    checkOutput("post_reset_grant_seen", last_grant, 32'h1);
    checkOutput("post_reset_first_fetch", last_grant_addr, RESET_PC);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] randomized traffic");
    fixed_lat = 0;
    max_lat = 4;
    dut_delivered = 0;
    for (int i = 0; i < 500; i++) begin
      h = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 11) == 0);
      g = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else t = $urandom() & 32'h0000_0FFF;
      applyStimulus(h, b, t, g);
      if (!h && !b && (valid_out === 1'b1)) dut_delivered++;
    end
    checkOutput("random_progress", (dut_delivered > 40) ? 32'h1 : 32'h0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
